spi_rcv: RTL and testbench
==========================

Name: spi_rcv

Overview:
SPI peripheral-side receiver; the opposite end of the team's spi_gen transmitter.
- Watches an active-low select, a serial clock and a data line, all driven by a controller.
- Deserialises MESSAGE_WIDTH bits, MSB first, sampling on the serial-clock rising edge (mode 0).
- Presents each complete word with a one-cycle valid pulse and flags malformed frames.
- Sits between off-chip or loopback SPI pins and a byte-oriented consumer.

Parameters:
- MESSAGE_WIDTH, 8, bits per frame; ≥2.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers; ≥2.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- data_in  input  1  serial data from controller
- spi_clk_in  input  1  serial clock from controller; idles low
- sel_in  input  1  active-low chip select
- data_out  output  MESSAGE_WIDTH  last complete word received
- valid_out  output  1  one-cycle pulse, data_out newly updated
- error_out  output  1  one-cycle pulse, framing error

Behaviour:
- Single clock domain clk_in; reset is synchronous, active-high.
- Reset values: data_out=0, valid_out=0, error_out=0, state=IDLE, bit count=0, shift register=0, synchronizer flops=idle levels (sel=1, sclk=0, data=0).
- Input synchronization:
  - data_in, spi_clk_in and sel_in each pass through SYNC_STAGES flops of equal depth, so relative timing is preserved.
  - All logic below uses the synchronized copies: d_s, sclk_s, sel_s.
- Edge detection: one extra register holds the previous sclk_s and sel_s.
  - sclk_rise = sclk_s & ~sclk_prev.
  - sel_fall = ~sel_s & sel_prev.
  - sel_rise = sel_s & ~sel_prev.
- Input timing requirement: each spi_clk_in phase is held ≥2 clk_in cycles; data_in is stable across each rising edge.
- States:
  - IDLE:
    - On sel_fall → RECV; clear bit count and shift register.
    - sel already low with no observed falling edge (e.g. low at reset release) → stay in IDLE.
  - RECV:
    - On sclk_rise: shift register <= {shift[W-2:0], d_s}; bit count++.
    - When the W-th rising edge is taken: next cycle data_out <= {shift[W-2:0], d_s}, valid_out=1 for exactly one cycle, state → DONE.
    - On sel_rise before W edges: error_out=1 for one cycle, data_out unchanged, no valid_out, state → IDLE.
    - sclk_rise and sel_rise in the same cycle: sel_rise wins; the edge is discarded.
  - DONE:
    - On sel_rise → IDLE, no pulse.
    - Any sclk_rise while still selected (overrun) → error_out pulse for one cycle; stay in DONE; data_out keeps the completed word.
- Latency: a pin-level rising edge reaches sclk_rise SYNC_STAGES cycles later. valid_out asserts SYNC_STAGES+1 cycles after the W-th pin-level rising edge.
- Back-to-back frames: sel_fall is accepted in the same cycle the machine enters IDLE. A minimum sel-high time of 2 clk_in cycles must be supported.
- data_out holds its value until the next valid word.
- valid_out and error_out are never high in the same cycle.
- Bit counter width: $clog2(MESSAGE_WIDTH)+1; no wrap inside a frame.
- Reset mid-frame: immediate return to IDLE, partial word discarded, no error pulse.

Decomposition:
- Package spi_pkg holds:
  - typedef enum logic [1:0] {IDLE, RECV, DONE} spi_rcv_state_t
  - localparam SPI_SEL_IDLE = 1'b1
  - localparam SPI_CLK_IDLE = 1'b0
- One sub-module, sync_ff #(STAGES, RESET_VAL): a generic N-flop synchronizer, instantiated three times.

Test Plan:
- Loopback from spi_gen (MESSAGE_WIDTH=8, BIT_DUR=2), msg 8'hA5 → exactly one valid_out pulse with data_out=8'hA5, error_out never high.
- Two frames back-to-back, 8'h3C then 8'hC3, with sel high 2 cycles between them → two valid pulses, data_out 8'h3C then 8'hC3.
- Bit-banged frame: 3 clock rises (bits 1,0,1), then sel high → one error_out pulse, no valid_out, data_out retains its prior value.
- Full 8'hFF frame plus a 9th clock rise before sel high → valid_out with 8'hFF, then one error_out pulse; data_out stays 8'hFF.
- rst_in asserted for 1 cycle after 4 bits of 8'h0F, sel still low, remaining bits clocked → no valid_out or error_out until a new sel falling edge; the next full frame 8'h81 is received correctly.
- sel_in low and clocks toggling while rst_in deasserts → receiver stays IDLE; no pulses until sel goes high and then low again.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and idle pin levels for the SPI peripheral-side receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } spi_rcv_state_t;

  localparam logic SPI_SEL_IDLE = 1'b1;
  localparam logic SPI_CLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_rcv_sync_ff.sv
// Generic N-flop synchronizer with a synchronous, active-high reset to a chosen level.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_rcv.sv
// SPI mode-0 peripheral receiver: synchronizes the pins, deserialises MSB-first words
// and reports complete words (valid_out) or malformed frames (error_out) as single-cycle pulses.
module spi_rcv
  import spi_pkg::*;
#(
  parameter int MESSAGE_WIDTH = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     data_in,
  input  logic                     spi_clk_in,
  input  logic                     sel_in,
  output logic [MESSAGE_WIDTH-1:0] data_out,
  output logic                     valid_out,
  output logic                     error_out
);

  localparam int                 CNT_W      = $clog2(MESSAGE_WIDTH) + 1;
  localparam int                 FLUSH_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(MESSAGE_WIDTH - 1);

  logic d_s;
  logic sclk_s;
  logic sel_s;
  logic sclk_prev;
  logic sel_prev;
  logic [FLUSH_W-1:0] flush;
  logic armed;
  logic sclk_rise;
  logic sel_fall;
  logic sel_rise;

  spi_rcv_state_t           state;
  spi_rcv_state_t           state_nxt;
  logic [MESSAGE_WIDTH-1:0] shift;
  logic [MESSAGE_WIDTH-1:0] shift_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic [MESSAGE_WIDTH-1:0] data_nxt;
  logic                     valid_nxt;
  logic                     error_nxt;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .clk (clk_in),
    .rst (rst_in),
    .d   (data_in),
    .q   (d_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CLK_IDLE)) u_sync_sclk (
    .clk (clk_in),
    .rst (rst_in),
    .d   (spi_clk_in),
    .q   (sclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_SEL_IDLE)) u_sync_sel (
    .clk (clk_in),
    .rst (rst_in),
    .d   (sel_in),
    .q   (sel_s)
  );

  // Previous synchronized levels for edge detection, plus a post-reset flush window.
  // The synchronizers reset to idle levels, so a pin held low across reset would
  // otherwise look like a fresh select falling edge once the chain fills.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sclk_prev <= SPI_CLK_IDLE;
      sel_prev  <= SPI_SEL_IDLE;
      flush     <= FLUSH_LOAD;
    end else begin
      sclk_prev <= sclk_s;
      sel_prev  <= sel_s;
      if (flush != {FLUSH_W{1'b0}}) begin
        flush <= flush - FLUSH_W'(1);
      end else begin
        flush <= flush;
      end
    end
  end

  assign armed     = (flush == {FLUSH_W{1'b0}});
  assign sclk_rise = armed & sclk_s & ~sclk_prev;
  assign sel_fall  = armed & ~sel_s & sel_prev;
  assign sel_rise  = armed & sel_s & ~sel_prev;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, datapath updates and output pulses; a select rise outranks a clock edge.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    cnt_nxt   = cnt;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sel_fall) begin
          state_nxt = RECV;
          shift_nxt = {MESSAGE_WIDTH{1'b0}};
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end
      RECV: begin
        if (sel_rise) begin
          error_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          shift_nxt = {shift[MESSAGE_WIDTH-2:0], d_s};
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            data_nxt  = {shift[MESSAGE_WIDTH-2:0], d_s};
            valid_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = RECV;
          end
        end else begin
          state_nxt = RECV;
        end
      end
      DONE: begin
        if (sel_rise) begin
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          error_nxt = 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and registered output pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shift     <= {MESSAGE_WIDTH{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      data_out  <= {MESSAGE_WIDTH{1'b0}};
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      shift     <= shift_nxt;
      cnt       <= cnt_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      error_out <= error_nxt;
    end
  end

endmodule

// File: tb/tb_spi_rcv.sv
// Randomized scoreboard bench for spi_rcv: frames are bit-banged on the pins, a frame-level
// model queues the expected pulses, and a monitor checks each pulse as it appears.
module tb_spi_rcv;

  localparam int W = 8;

  typedef struct {
    bit         is_err;
    logic [W-1:0] data;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sdata;
  logic         sclk;
  logic         sel;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         error_out;

  ev_t          exp_q[$];
  logic [W-1:0] last_word;
  int           n_checks = 0;
  int           n_fail   = 0;

  spi_rcv #(.MESSAGE_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .data_in    (sdata),
    .spi_clk_in (sclk),
    .sel_in     (sel),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .error_out  (error_out)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Frame-level model: fewer than W edges is a framing error, the W-th edge yields
  // the word, and every extra edge while still selected is an overrun error.
  task automatic expect_frame(input logic [W-1:0] word, input int nedges);
    ev_t e;
    if (nedges < W) begin
      e.is_err = 1'b1; e.data = last_word; exp_q.push_back(e);
    end else begin
      e.is_err = 1'b0; e.data = word; exp_q.push_back(e);
      last_word = word;
      for (int k = W; k < nedges; k++) begin
        e.is_err = 1'b1; e.data = word; exp_q.push_back(e);
      end
    end
  endtask

  task automatic clock_bits(input logic [W-1:0] word, input int first, input int nedges, input int ph);
    for (int i = first; i < nedges; i++) begin
      if (i < W) sdata = word[W-1-i];
      else       sdata = 1'($urandom_range(1, 0));
      cyc(ph);
      sclk = 1'b1;
      cyc(ph);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] word, input int nedges, input int ph, input int gap);
    expect_frame(word, nedges);
    sel = 1'b0;
    clock_bits(word, 0, nedges, ph);
    cyc(ph);
    sel = 1'b1;
    cyc(gap);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    if (valid_out === 1'b1 || error_out === 1'b1) begin
      chk("pulse_exclusive", {31'd0, valid_out & error_out}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b data=%0h, expected no pulse",
                 valid_out, error_out, data_out);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_is_err", {31'd0, error_out}, {31'd0, e.is_err});
        chk("pulse_data", {24'd0, data_out}, {24'd0, e.data});
      end
    end
  end

  initial begin
    int ph;
    int gap;
    int n;
    logic [W-1:0] w;
    rst       = 1'b1;
    sdata     = 1'b0;
    sclk      = 1'b0;
    sel       = 1'b1;
    last_word = '0;
    cyc(3);
    chk("reset_data", {24'd0, data_out}, 32'd0);
    chk("reset_valid", {31'd0, valid_out}, 32'd0);
    chk("reset_error", {31'd0, error_out}, 32'd0);

    // Select low and clock toggling across reset release: must stay idle.
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst = 1'b0;
      sdata = 1'(i);
      cyc(2); sclk = 1'b1;
      cyc(2); sclk = 1'b0;
    end
    sel = 1'b1;
    cyc(3);

    // Loopback-style frame, then back-to-back frames with a 2-cycle select-high gap.
    send_frame(8'hA5, W, 2, 4);
    send_frame(8'h3C, W, 2, 2);
    send_frame(8'hC3, W, 2, 4);
    // Short frame of 3 bits, then a full frame with one overrun edge.
    send_frame(8'hA0, 3, 2, 4);
    send_frame(8'hFF, W + 1, 2, 4);
    chk("hold_after_overrun", {24'd0, data_out}, 32'h0000_00FF);

    // Reset mid-frame after 4 bits of 8'h0F; remaining bits must be ignored.
    sel = 1'b0;
    clock_bits(8'h0F, 0, 4, 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    last_word = '0;
    clock_bits(8'h0F, 4, W, 2);
    cyc(2);
    sel = 1'b1;
    cyc(4);
    chk("data_after_midframe_reset", {24'd0, data_out}, 32'd0);
    send_frame(8'h81, W, 2, 4);

    // Randomized frames: mostly complete, some short or overrun.
    for (int f = 0; f < 40; f++) begin
      w   = W'($urandom);
      ph  = $urandom_range(4, 2);
      gap = $urandom_range(5, 2);
      if ($urandom_range(9, 0) < 6) n = W;
      else                          n = $urandom_range(W + 2, 0);
      send_frame(w, n, ph, gap);
    end

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) cyc(1);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_data", {24'd0, data_out}, {24'd0, last_word});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
